wbicape_warmboot: RTL and testbench
===================================

// Module: wbicape_warmboot
// PURPOSE
// - Wishbone master that sits directly upstream of the ICAPE2 wishbone slave.
// - On one request it writes a warm-boot start address to the WBSTAR register,
//   then writes IPROG to the CMD register, so the FPGA reconfigures from that address.
// - Each slave transaction takes tens of slow ICAPE clocks, so every access is
//   guarded by an ack timeout.
// PARAMETERS
// - LGTIMEOUT    10      log2 of ack timeout in i_clk cycles; counted from stb issue
// - WBSTAR_ADDR  5'h10   slave register address of WBSTAR
// - CMD_ADDR     5'h04   slave register address of CMD
// - IPROG_CMD    32'h0f  value written to CMD
// PORTS
// - i_clk         in   1   single clock; all logic on posedge
// - i_areset_n    in   1   reset, asynchronous assert, active low
// - i_reboot_stb  in   1   one-cycle request; accepted only when !o_busy
// - i_reboot_addr in   32  warm-boot start address to write to WBSTAR
// - o_busy        out  1   high from accept until return to IDLE
// - o_err         out  1   sticky error: timeout (or verify mismatch)
// - o_wb_cyc      out  1   master cycle
// - o_wb_stb      out  1   master strobe, pipelined wishbone
// - o_wb_we       out  1   1 = write, 0 = read
// - o_wb_addr     out  5   slave register address
// - o_wb_data     out  32  write data
// - i_wb_ack      in   1   slave ack
// - i_wb_stall    in   1   slave stall
// - i_wb_data     in   32  slave read data, valid with i_wb_ack
// BEHAVIOUR
// - Reset (async, i_areset_n=0): state=IDLE.
//   All outputs 0: o_busy, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data.
// - IDLE: if i_reboot_stb:
//   - latch i_reboot_addr into r_addr; clear o_err; o_busy<=1.
//   - next cycle: cyc=stb=we=1, addr=WBSTAR_ADDR, data=r_addr; enter WR_STAR.
// - Strobe rule: stb stays high until a cycle with stb && !i_wb_stall, then drops.
//   - Exactly one request per access.
//   - cyc stays high until i_wb_ack.
// - WR_STAR: on ack, drop cyc. Next cycle, issue the CMD write
//   (addr=CMD_ADDR, data=IPROG_CMD, we=1) and enter WR_CMD.
//   - With WBICAPE_VERIFY_EN defined, enter RD_STAR instead (see CONFIGURATION).
// - WR_CMD: on ack, drop cyc and enter IDLE; o_busy<=0. The bus is idle one cycle between accesses.
// - Timeout: counter cleared when stb is raised; increments each cycle while cyc && !ack.
//   - If it reaches 2**LGTIMEOUT-1 without ack: cyc=stb=0, o_err<=1, IDLE, o_busy<=0.
//   - No further accesses in that sequence.
//   - Ack in the same cycle as expiry: ack wins, no error.
// - i_reboot_stb while o_busy: ignored, not queued.
// - i_reboot_stb in the same cycle o_busy falls: ignored; accepted from the next cycle.
// - Stray i_wb_ack while cyc=0: ignored.
// - Reset mid-transaction: cyc/stb drop asynchronously; the sequence is abandoned and not resumed.
// - Latency with zero-wait slave (ack one cycle after stb):
//   - stb for WBSTAR in cycle N+1 after accept in N.
//   - CMD stb in N+4; o_busy low in N+6.
// CONFIGURATION
// - WBICAPE_VERIFY_EN defined:
//   - after WR_STAR ack, state RD_STAR issues a read (we=0, addr=WBSTAR_ADDR).
//   - on ack, compare i_wb_data with r_addr.
//     - Equal: proceed to WR_CMD.
//     - Unequal: o_err<=1, IDLE, IPROG never sent.
//   - The read is timeout-guarded like any access.
// - WBICAPE_VERIFY_EN undefined: no read state, no comparator; WR_STAR goes straight to WR_CMD.
// TESTING
// - Slave with 3-cycle stall and 20-cycle ack; request with addr 32'h0040_0000:
//   - write 32'h0040_0000 to 5'h10, then 32'h0f to 5'h04.
//   - one stb accepted per access; o_err=0; o_busy returns to 0.
// - Slave never acks, LGTIMEOUT=4:
//   - cyc drops 15 cycles after stb; o_err=1; no CMD write.
//   - next request clears o_err.
// - Second i_reboot_stb mid-sequence (addr 32'h1234):
//   - ignored; only the first address is written.
// - i_areset_n low during WR_CMD wait:
//   - cyc/stb/busy go 0 that cycle without an i_clk edge; no later accesses.
// - VERIFY_EN, read returns 32'h0040_0000:
//   - IPROG is written.
// - VERIFY_EN, read returns 32'h0:
//   - o_err=1; no access to 5'h04.
// - Ack coincident with timeout expiry: no error; sequence continues.

Source files
------------

// File: rtl/wbicape_warmboot.sv
// Warm-boot sequencer: writes WBSTAR, then IPROG to CMD, on the ICAPE2 wishbone slave.
// Optional feature macro WBICAPE_VERIFY_EN: read WBSTAR back and compare before IPROG.
module wbicape_warmboot #(
    parameter int          LGTIMEOUT   = 10,
    parameter logic [4:0]  WBSTAR_ADDR = 5'h10,
    parameter logic [4:0]  CMD_ADDR    = 5'h04,
    parameter logic [31:0] IPROG_CMD   = 32'h0f
) (
    input  logic        i_clk,
    input  logic        i_areset_n,
    input  logic        i_reboot_stb,
    input  logic [31:0] i_reboot_addr,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_STAR = 3'd1;
    localparam logic [2:0] S_PRE_CMD = 3'd2;
    localparam logic [2:0] S_WR_CMD  = 3'd3;
`ifdef WBICAPE_VERIFY_EN
    localparam logic [2:0] S_PRE_RD  = 3'd4;
    localparam logic [2:0] S_RD_STAR = 3'd5;
`endif

    localparam logic [LGTIMEOUT-1:0] CNT_ONE = {{(LGTIMEOUT-1){1'b0}}, 1'b1};
    // Last count before expiry; an ack in that cycle still completes the access.
    localparam logic [LGTIMEOUT-1:0] TO_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

    logic [2:0]           state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [4:0]           wbaddr_q, wbaddr_d;
    logic [31:0]          wbdata_q, wbdata_d;
    logic [LGTIMEOUT-1:0] cnt_q, cnt_d;

    logic done;
    logic timeout;

    assign done    = cyc_q && i_wb_ack;
    assign timeout = cyc_q && !i_wb_ack && (cnt_q == TO_LAST);

`ifndef WBICAPE_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^i_wb_data;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        err_d    = err_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        wbaddr_d = wbaddr_q;
        wbdata_d = wbdata_q;
        cnt_d    = cnt_q;

        if (stb_q && !i_wb_stall) begin
            stb_d = 1'b0;
        end
        if (cyc_q && !i_wb_ack) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_reboot_stb) begin
                    addr_d   = i_reboot_addr;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    we_d     = 1'b1;
                    wbaddr_d = WBSTAR_ADDR;
                    wbdata_d = i_reboot_addr;
                    cnt_d    = '0;
                    state_d  = S_WR_STAR;
                end
            end
            S_WR_STAR: begin
                if (done) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
`ifdef WBICAPE_VERIFY_EN
                    state_d = S_PRE_RD;
`else
                    state_d = S_PRE_CMD;
`endif
                end
            end
`ifdef WBICAPE_VERIFY_EN
            S_PRE_RD: begin
                cyc_d    = 1'b1;
                stb_d    = 1'b1;
                we_d     = 1'b0;
                wbaddr_d = WBSTAR_ADDR;
                wbdata_d = '0;
                cnt_d    = '0;
                state_d  = S_RD_STAR;
            end
            S_RD_STAR: begin
                if (done) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (i_wb_data == addr_q) begin
                        state_d = S_PRE_CMD;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_PRE_CMD: begin
                cyc_d    = 1'b1;
                stb_d    = 1'b1;
                we_d     = 1'b1;
                wbaddr_d = CMD_ADDR;
                wbdata_d = IPROG_CMD;
                cnt_d    = '0;
                state_d  = S_WR_CMD;
            end
            S_WR_CMD: begin
                if (done) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Expiry abandons the whole sequence, whatever access was running.
        if (timeout) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            wbaddr_q <= '0;
            wbdata_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            wbaddr_q <= wbaddr_d;
            wbdata_q <= wbdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_err     = err_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = we_q;
    assign o_wb_addr = wbaddr_q;
    assign o_wb_data = wbdata_q;

endmodule

// File: tb/tb_wbicape_warmboot.sv
// Bench for wbicape_warmboot: scripted slave plus a per-request reference model.
// Honors WBICAPE_VERIFY_EN the same way the design does.
module tb_wbicape_warmboot;

    localparam int LG = 5;
    localparam int TO = (1 << LG) - 1;
    localparam logic [4:0] A_STAR = 5'h10;
    localparam logic [4:0] A_CMD  = 5'h04;
`ifdef WBICAPE_VERIFY_EN
    localparam int NPRE = 3;
`else
    localparam int NPRE = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reboot_stb = 1'b0;
    logic [31:0] reboot_addr = '0;
    logic        busy, err, cyc, stb, we;
    logic [4:0]  wbaddr;
    logic [31:0] wdata, rdata;
    logic        wb_ack, wb_stall;

    always #5 clk = ~clk;

    wbicape_warmboot #(.LGTIMEOUT(LG)) u_dut (
        .i_clk(clk), .i_areset_n(rst_n),
        .i_reboot_stb(reboot_stb), .i_reboot_addr(reboot_addr),
        .o_busy(busy), .o_err(err),
        .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we),
        .o_wb_addr(wbaddr), .o_wb_data(wdata),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic w, input logic [4:0] a,
                                       input logic [31:0] d);
        return {26'd0, w, a, d};
    endfunction

    // Scripted slave: stalls cfg_stall cycles, acks cfg_lat cycles after
    // accepting the strobe (0 = never acks).
    int          cfg_stall = 0;
    int          cfg_lat = 1;
    logic [31:0] cfg_rd = '0;
    logic        stray = 1'b0;
    logic        ack_q = 1'b0;
    int          st_left = 0;
    int          ack_left = 0;
    logic [63:0] log_q[$];

    assign wb_stall = cyc && stb && (st_left != 0);
    assign wb_ack   = ack_q | stray;
    assign rdata    = ack_q ? cfg_rd : 32'hdead_beef;

    always @(posedge clk) begin
        ack_q <= 1'b0;
        if (!cyc) begin
            st_left  <= cfg_stall;
            ack_left <= 0;
        end else if (stb && wb_stall) begin
            st_left <= st_left - 1;
        end else if (stb) begin
            log_q.push_back(mk(we, wbaddr, we ? wdata : 32'h0));
            if (cfg_lat == 1) ack_q <= 1'b1;
            else if (cfg_lat > 1) ack_left <= cfg_lat - 1;
        end else if (ack_left > 0) begin
            if (ack_left == 1) ack_q <= 1'b1;
            ack_left <= ack_left - 1;
        end
    end

    // Bus monitor: cyc run-lengths, strobe cycles per access, busy/gap cycles.
    int   busy_cnt = 0;
    int   gap_cnt = 0;
    int   cur_len = 0;
    int   cur_stb = 0;
    logic cyc_prev = 1'b0;
    int   lens_q[$];
    int   stbs_q[$];

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (busy && !cyc) gap_cnt++;
        if (cyc) begin
            cur_len++;
            if (stb) cur_stb++;
        end else if (cyc_prev) begin
            lens_q.push_back(cur_len);
            stbs_q.push_back(cur_stb);
            cur_len = 0;
            cur_stb = 0;
        end
        cyc_prev = cyc;
    end

    task automatic run_req(input logic [31:0] a, input int st, input int lat,
                           input logic [31:0] rd, input bit hold);
        logic [63:0] exp_t[$];
        int          exp_l[$];
        int          exp_s[$];
        logic [63:0] plan[$];
        bit          exp_e;
        int          acc, b0, g0, l0, t0, nb, ncyc;
        bit          timed, seen;

        // Reference: each planned access either completes after acc cycles
        // or expires after TO cycles and ends the sequence with an error.
        acc   = st + 1 + lat;
        timed = (lat == 0) || (acc > TO);
        plan.push_back(mk(1'b1, A_STAR, a));
`ifdef WBICAPE_VERIFY_EN
        plan.push_back(mk(1'b0, A_STAR, 32'h0));
`endif
        plan.push_back(mk(1'b1, A_CMD, 32'h0f));
        exp_e = 1'b0;
        foreach (plan[i]) begin
            exp_t.push_back(plan[i]);
            exp_l.push_back(timed ? TO : acc);
            exp_s.push_back(st + 1);
            if (timed) begin
                exp_e = 1'b1;
                break;
            end
            if (plan[i][37] == 1'b0 && rd != a) begin
                exp_e = 1'b1;
                break;
            end
        end
        nb = 0;
        foreach (exp_l[i]) nb += exp_l[i];
        nb += exp_l.size() - 1;

        cfg_stall = st;
        cfg_lat   = lat;
        cfg_rd    = rd;
        @(negedge clk);
        b0 = busy_cnt; g0 = gap_cnt; l0 = lens_q.size(); t0 = log_q.size();
        reboot_stb  = 1'b1;
        reboot_addr = a;
        @(negedge clk);
        check("busy_on", busy, 1'b1);
        check("err_clr", err, 1'b0);
        if (hold) reboot_addr = 32'h1234;
        else reboot_stb = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!busy) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        reboot_stb = 1'b0;
        check("done_wait", seen, 1'b1);
        repeat (3) @(negedge clk);

        check("busy_off", busy, 1'b0);
        check("cyc_off", cyc, 1'b0);
        check("err", err, exp_e);
        check("ntxn", log_q.size() - t0, exp_t.size());
        foreach (exp_t[i])
            if (t0 + i < log_q.size()) check("txn", log_q[t0 + i], exp_t[i]);
        ncyc = lens_q.size() - l0;
        check("nacc", ncyc, exp_l.size());
        foreach (exp_l[i])
            if (l0 + i < lens_q.size()) begin
                check("cyc_len", lens_q[l0 + i], exp_l[i]);
                check("stb_cnt", stbs_q[l0 + i], exp_s[i]);
            end
        check("busy_len", busy_cnt - b0, nb);
        check("gaps", gap_cnt - g0, exp_l.size() - 1);
    endtask

    initial begin
        int t0;
        bit seen;
        logic [31:0] ra;

        #3;
        check("reset_out", {busy, err, cyc, stb, we, wbaddr, wdata},
              '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait slave: busy spans five cycles.
        run_req(32'h0000_1000, 0, 1, 32'h0000_1000, 1'b0);
        // Stalling, slow slave with a second request held throughout.
        run_req(32'h0040_0000, 3, 20, 32'h0040_0000, 1'b1);
        // Never acks, then the next request clears the error.
        run_req(32'h0040_0000, 0, 0, 32'h0040_0000, 1'b0);
        // Ack coincident with expiry, then one cycle too late.
        run_req(32'h00ab_0000, 0, TO - 1, 32'h00ab_0000, 1'b0);
        run_req(32'h00ab_0000, 0, TO, 32'h00ab_0000, 1'b0);
        run_req(32'h00cd_0000, 2, TO - 3, 32'h00cd_0000, 1'b0);
`ifdef WBICAPE_VERIFY_EN
        run_req(32'h0040_0000, 1, 3, 32'h0000_0000, 1'b0);
`endif
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            run_req(ra, $urandom_range(0, 3), $urandom_range(0, 35),
                    ($urandom_range(0, 3) == 0) ? ~ra : ra,
                    1'($urandom_range(0, 1)));
        end

        // Stray acks while idle are ignored.
        t0 = log_q.size();
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_busy", busy, 1'b0);
        check("stray_cyc", cyc, 1'b0);
        check("stray_txn", log_q.size() - t0, 0);

        // Reset while the CMD write waits for its ack.
        cfg_stall = 0;
        cfg_lat   = 25;
        cfg_rd    = 32'h0000_2000;
        @(negedge clk);
        t0 = log_q.size();
        reboot_stb  = 1'b1;
        reboot_addr = 32'h0000_2000;
        @(negedge clk);
        reboot_stb = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (log_q.size() - t0 >= NPRE) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("cmd_wait", seen, 1'b1);
        repeat (3) @(negedge clk);
        check("pre_rst_cyc", cyc, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {busy, cyc, stb}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_no_more", log_q.size() - t0, NPRE);
        check("rst_idle", {busy, cyc}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
